// File: rtl/div_unit_radix_if.sv
// Launch/result bundle of the iterative divider: the execute stage is the master,
// the divider is the slave.
interface div_unit_radix_if #(
    parameter int WIDTH = 32
);
    logic             start_div;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             is_signed_div;
    logic             div_type;
    logic [4:0]       reg_rd;
    logic             wen;
    logic             kill;
    logic [WIDTH-1:0] wdata_du;
    logic [4:0]       reg_rd_du;
    logic             wen_du;
    logic             busy_du;
    logic             done_du;

    // Launch protocol: start_div is taken only in a cycle where busy_du is low and
    // kill is low. Results are valid for the single cycle done_du is high, and
    // wdata_du/reg_rd_du/wen_du keep those values until the next done_du pulse.
    modport master (
        output start_div, rs1_data, rs2_data, is_signed_div, div_type, reg_rd, wen, kill,
        input  wdata_du, reg_rd_du, wen_du, busy_du, done_du
    );

    modport slave (
        input  start_div, rs1_data, rs2_data, is_signed_div, div_type, reg_rd, wen, kill,
        output wdata_du, reg_rd_du, wen_du, busy_du, done_du
    );
endinterface

// File: rtl/div_unit_radix.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) retiring BPC quotient bits per cycle.
// Optional last-result cache for DIV+REM pairs is enabled by defining DIV_RESULT_CACHE_EN.
module div_unit_radix #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    div_unit_radix_if.slave  du,
    output logic [1:0]       o_dbg_state
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] FIXUP  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_type;
    logic [4:0]       r_rd;
    logic             r_wen;
    logic [WIDTH-1:0] r_wdata;
    logic [4:0]       r_rd_du;
    logic             r_wen_du;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_sp_q;
    logic [WIDTH-1:0] w_sp_r;
    logic             w_hit;
    logic [WIDTH-1:0] w_c_q;
    logic [WIDTH-1:0] w_c_r;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH:0]   w_rem_nx;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_fin_q;
    logic [WIDTH-1:0] w_fin_r;
    logic             w_sel_type;
    logic [4:0]       w_sel_rd;
    logic             w_sel_wen;
    logic             w_load_out;

    assign w_accept   = (r_state == IDLE) && du.start_div && !du.kill;
    assign w_a_neg    = du.is_signed_div && du.rs1_data[WIDTH-1];
    assign w_b_neg    = du.is_signed_div && du.rs2_data[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -du.rs1_data : du.rs1_data;
    assign w_b_mag    = w_b_neg ? -du.rs2_data : du.rs2_data;
    assign w_div_zero = (du.rs2_data == '0);
    assign w_ovf      = du.is_signed_div && (du.rs1_data == {1'b1, {(WIDTH-1){1'b0}}})
                        && (&du.rs2_data);
    assign w_special  = w_div_zero || w_ovf;
    assign w_sp_q     = w_div_zero ? '1 : du.rs1_data;
    assign w_sp_r     = w_div_zero ? du.rs1_data : '0;

`ifdef DIV_RESULT_CACHE_EN
    logic             r_c_valid;
    logic [WIDTH-1:0] r_c_a;
    logic [WIDTH-1:0] r_c_b;
    logic             r_c_sgn;
    logic [WIDTH-1:0] r_c_q;
    logic [WIDTH-1:0] r_c_r;
    logic [WIDTH-1:0] r_key_a;
    logic [WIDTH-1:0] r_key_b;
    logic             r_key_sgn;

    assign w_hit = r_c_valid && (r_c_a == du.rs1_data) && (r_c_b == du.rs2_data)
                   && (r_c_sgn == du.is_signed_div);
    assign w_c_q = r_c_q;
    assign w_c_r = r_c_r;
`else
    assign w_hit = 1'b0;
    assign w_c_q = '0;
    assign w_c_r = '0;
`endif

    // One restoring step per retired bit; the quotient shifts in where the dividend shifts out.
    always_comb begin
        logic [WIDTH:0]   v_rem;
        logic [WIDTH-1:0] v_quo;
        logic [WIDTH:0]   v_sh;
        v_rem = r_rem;
        v_quo = r_quo;
        v_sh  = '0;
        for (int i = 0; i < BPC; i++) begin
            v_sh  = {v_rem[WIDTH-1:0], v_quo[WIDTH-1]};
            v_quo = {v_quo[WIDTH-2:0], 1'b0};
            if (v_sh >= {1'b0, r_dvs}) begin
                v_rem    = v_sh - {1'b0, r_dvs};
                v_quo[0] = 1'b1;
            end else begin
                v_rem = v_sh;
            end
        end
        w_rem_nx = v_rem;
        w_quo_nx = v_quo;
    end

    assign w_q_fix = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix = r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (w_special || w_hit) ? DONE : DIVIDE;
            DIVIDE:  if (r_cnt == '0) w_next = FIXUP;
            FIXUP:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (du.kill && (r_state != IDLE)) w_next = IDLE;
    end

    // Results enter DONE either straight from IDLE (special case / cache hit) or from FIXUP.
    assign w_load_out = (w_next == DONE);
    assign w_fin_q    = (r_state == IDLE) ? (w_special ? w_sp_q : w_c_q) : w_q_fix;
    assign w_fin_r    = (r_state == IDLE) ? (w_special ? w_sp_r : w_c_r) : w_r_fix;
    assign w_sel_type = (r_state == IDLE) ? du.div_type : r_type;
    assign w_sel_rd   = (r_state == IDLE) ? du.reg_rd   : r_rd;
    assign w_sel_wen  = (r_state == IDLE) ? du.wen      : r_wen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_type   <= 1'b0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_rd_du  <= '0;
            r_wen_du <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= w_load_out;
            if (w_accept) begin
                r_quo   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= '0;
                r_cnt   <= CW'(N - 1);
                r_q_neg <= du.is_signed_div && (du.rs1_data[WIDTH-1] ^ du.rs2_data[WIDTH-1]);
                r_r_neg <= du.is_signed_div && du.rs1_data[WIDTH-1];
                r_type  <= du.div_type;
                r_rd    <= du.reg_rd;
                r_wen   <= du.wen;
            end else if (r_state == DIVIDE) begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_load_out) begin
                r_wdata  <= w_sel_type ? w_fin_r : w_fin_q;
                r_rd_du  <= w_sel_rd;
                r_wen_du <= w_sel_wen;
            end
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    // The lookup key must survive DIVIDE, where r_quo is consumed as a shift register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_c_valid <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_sgn   <= 1'b0;
            r_c_q     <= '0;
            r_c_r     <= '0;
            r_key_a   <= '0;
            r_key_b   <= '0;
            r_key_sgn <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key_a   <= du.rs1_data;
                r_key_b   <= du.rs2_data;
                r_key_sgn <= du.is_signed_div;
            end
            if (w_load_out) begin
                r_c_valid <= 1'b1;
                r_c_a     <= (r_state == IDLE) ? du.rs1_data      : r_key_a;
                r_c_b     <= (r_state == IDLE) ? du.rs2_data      : r_key_b;
                r_c_sgn   <= (r_state == IDLE) ? du.is_signed_div : r_key_sgn;
                r_c_q     <= w_fin_q;
                r_c_r     <= w_fin_r;
            end
        end
    end
`endif

    assign du.wdata_du  = r_wdata;
    assign du.reg_rd_du = r_rd_du;
    assign du.wen_du    = r_wen_du;
    assign du.busy_du   = r_busy;
    assign du.done_du   = r_done;
    assign o_dbg_state  = r_state;
endmodule

// File: doc/div_unit_radix.md
# div_unit_radix

Parametrised iterative integer divider for the RISC-V M-extension execute stage, the next generation of the fixed 32-bit divide unit. It implements DIV/DIVU/REM/REMU with configurable operand width and bits retired per cycle. It adds a pipeline-flush abort and single-cycle handling of divide-by-zero and signed overflow. It sits beside the ALU and multiplier: the execute stage launches an operation and stalls on `busy_du`, and writeback takes `wdata_du`/`reg_rd_du`/`wen_du` on `done_du`.

## Interface

- `WIDTH`, 32, operand and result width; must be a multiple of `BPC`.
- `BPC`, 1, quotient bits retired per cycle; legal values are 1 or 2.
- `CLK` input 1: clock, rising edge.
- `nRST` input 1: asynchronous, active-low reset.
- `start_div` input 1: launch request; sampled only while `busy_du`=0.
- `rs1_data` input WIDTH: dividend.
- `rs2_data` input WIDTH: divisor.
- `is_signed_div` input 1: 1 = DIV/REM, 0 = DIVU/REMU.
- `div_type` input 1: 0 = quotient result, 1 = remainder result.
- `reg_rd` input 5: destination register, carried with the operation.
- `wen` input 1: write enable, carried with the operation.
- `kill` input 1: synchronous abort of the in-flight operation.
- `wdata_du` output WIDTH: result.
- `reg_rd_du` output 5: destination register of the result.
- `wen_du` output 1: write enable of the result.
- `busy_du` output 1: an operation is in flight.
- `done_du` output 1: one-cycle pulse; the result outputs are valid.

## Operation

- The FSM has four states: IDLE, DIVIDE, FIXUP, DONE. `busy_du` = (state != IDLE).
- **Accept.** In IDLE with `start_div`=1 and `kill`=0, the unit latches the following:
  - |rs1| and |rs2| (magnitudes only when `is_signed_div`=1);
  - the quotient sign (rs1[MSB]^rs2[MSB]) and the remainder sign (rs1[MSB]);
  - `div_type`, `reg_rd` and `wen`.
- **Special cases.** These go directly to DONE on the next cycle:
  - Divisor = 0: quotient = all-ones, remainder = rs1.
  - Signed, rs1 = 1 followed by WIDTH-1 zeros, rs2 = all-ones: quotient = rs1, remainder = 0.
- **DIVIDE.** Restoring division for N = WIDTH/BPC cycles, retiring BPC quotient bits per cycle, MSB first. The partial remainder is WIDTH+1 bits wide. A down-counter is loaded with N-1 on entry, and the state moves to FIXUP when the counter reaches 0.
- **FIXUP.** One cycle. Negate the quotient if its sign is 1, and negate the remainder if the remainder sign is 1. Both are negated only for signed operations, in two's complement, modulo 2^WIDTH. Then move to DONE.
- **DONE.** One cycle. `done_du`=1; `wdata_du` is the quotient or remainder selected by `div_type`; `reg_rd_du` and `wen_du` are the latched values. The next state is IDLE.
- `start_div` is ignored whenever `busy_du`=1.
- `wdata_du`, `reg_rd_du` and `wen_du` hold their values after DONE until the next DONE.
- **Kill.** `kill`=1 in any non-IDLE state returns the unit to IDLE on the next edge:
  - `done_du` is not raised;
  - the result outputs are not updated.
  - `kill` takes priority over the DONE transition.
  - `kill` with `start_div` in IDLE means the start is ignored.
- **Reset.** `nRST`=0, including mid-operation, forces IDLE. The outputs reset as follows:
  - `wdata_du`=0, `reg_rd_du`=0, `wen_du`=0, `busy_du`=0, `done_du`=0;
  - the cache, when present, is invalidated.

## Timing

- Cycle 0 is the accept cycle.
- Normal operation:
  - DIVIDE occupies cycles 1..N;
  - FIXUP is cycle N+1;
  - `done_du` is high in cycle N+2;
  - `busy_du` is high in cycles 1..N+2 and low in cycle N+3.
- With WIDTH=32 and BPC=1, `done_du` is high at cycle 34. With WIDTH=32 and BPC=2, it is high at cycle 18.
- Special cases: `done_du` and `busy_du` are high in cycle 1, and `busy_du` is low in cycle 2.
- A new start is accepted no earlier than the first cycle with `busy_du`=0.
- All outputs are registered.

## Configuration

- **`DIV_RESULT_CACHE_EN` defined.** The unit keeps a cache of the last completed operation:
  - stored fields: rs1, rs2, `is_signed_div`, quotient, remainder, and a valid bit;
  - the cache is written at every DONE, including special cases;
  - it is never written on kill.
  - On accept with a valid match on rs1, rs2 and `is_signed_div`, the unit goes directly to DONE in cycle 1 and returns the cached result selected by the new `div_type`.
  - This serves the DIV+REM fusion idiom.
- **`DIV_RESULT_CACHE_EN` not defined.** There is no cache logic, and every normal operation takes the full N+2 latency.

## Test plan

- DIVU 100/7, `div_type`=0, `reg_rd`=5, `wen`=1, WIDTH=32, BPC=1 -> `done_du` at cycle 34, `wdata_du`=14, `reg_rd_du`=5, `wen_du`=1; `busy_du` low at cycle 35.
- DIV and REM -7/2 (two separate launches) -> DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF; repeat with BPC=2 -> same results at cycle 18.
- DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5 at cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM of the same operands -> 0.
- DIVU 1000/3 with `kill` at cycle 10 -> no `done_du`, `busy_du`=0 at cycle 11, outputs unchanged; a new start at cycle 11 completes normally.
- With `DIV_RESULT_CACHE_EN`: DIVU 1000/3 (result 333), then REMU 1000/3 -> `done_du` at cycle 1, `wdata_du`=1. Without the macro -> the same REMU gives `done_du` at cycle 34.
